// File: rtl/pci_tgt_wr_post.sv
// Write-posting target: claims aligned burst writes to one BAR, queues {addr,data}
// pairs and drains them over a req/ack memory port. Reads are never claimed.
module pci_tgt_wr_post #(
    parameter int unsigned BAR_NUM = 2,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned AW      = 3
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          addr_vld,
    input  logic [31:0]   addr,
    input  logic [7:0]    base_hit,
    input  logic          s_wrdn,
    input  logic          s_data,
    input  logic          s_data_vld,
    input  logic [31:0]   adio_out,
    output logic          s_ready,
    output logic          s_term,
    output logic          s_abort,
    output logic          mem_req,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    output logic [AW:0]   fifo_level,
    output logic          overflow
);

    typedef enum logic [1:0] {IDLE, XFER, ABORT} state_t;

    localparam logic [AW:0]   LVL_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   LVL_TWO   = (AW+1)'(2);
    localparam logic [AW:0]   LVL_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    state_t        state_q;
    logic [31:0]   addr_cnt_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d, free_next;
    logic          s_ready_q, s_term_q, s_abort_q, overflow_q;
    logic [31:0]   addr_mem_q [DEPTH];
    logic [31:0]   data_mem_q [DEPTH];

    logic hit, full, push, drop, pop, room;
    logic unused_hit_bits;

    // base_hit is only trusted alongside the address-phase strobe
    assign hit  = addr_vld & base_hit[BAR_NUM] & s_wrdn;
    assign full = (level_q == LVL_DEPTH);
    assign push = (state_q == XFER) & s_data_vld & ~full;
    assign drop = (state_q == XFER) & s_data_vld & full;
    assign pop  = (level_q != '0) & mem_ack;
    assign unused_hit_bits = ^base_hit;

    always_comb begin
        level_d = level_q;
        if (push && !pop)
            level_d = level_q + LVL_ONE;
        else if (!push && pop)
            level_d = level_q - LVL_ONE;
    end

    // Keeping one spare entry absorbs the word already in flight when ready drops
    assign free_next = LVL_DEPTH - level_d;
    assign room      = (free_next >= LVL_TWO);

    always_ff @(posedge CLK) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= addr_cnt_q;
            data_mem_q[wr_ptr_q] <= adio_out;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            s_ready_q  <= 1'b0;
            s_term_q   <= 1'b0;
            s_abort_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            level_q <= level_d;
            if (drop) overflow_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    s_ready_q <= 1'b0;
                    s_term_q  <= 1'b0;
                    s_abort_q <= 1'b0;
                    if (hit && addr[1:0] == 2'b00) begin
                        state_q    <= XFER;
                        addr_cnt_q <= addr;
                        s_ready_q  <= room;
                        s_term_q   <= ~room;
                    end else if (hit) begin
                        state_q   <= ABORT;
                        s_abort_q <= 1'b1;
                    end
                end
                XFER: begin
                    if (push) addr_cnt_q <= addr_cnt_q + 32'd4;
                    if (!s_data) begin
                        state_q   <= IDLE;
                        s_ready_q <= 1'b0;
                        s_term_q  <= 1'b0;
                    end else begin
                        s_ready_q <= room;
                        s_term_q  <= ~room;
                    end
                end
                ABORT: begin
                    s_ready_q <= 1'b0;
                    s_term_q  <= 1'b0;
                    if (!s_data) begin
                        state_q   <= IDLE;
                        s_abort_q <= 1'b0;
                    end else begin
                        s_abort_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_ready    = s_ready_q;
    assign s_term     = s_term_q;
    assign s_abort    = s_abort_q;
    assign overflow   = overflow_q;
    assign fifo_level = level_q;
    assign mem_req    = (level_q != '0);
    assign mem_addr   = addr_mem_q[rd_ptr_q];
    assign mem_wdata  = data_mem_q[rd_ptr_q];

endmodule
